bch_chien_search: RTL

- Consumer of the error-locator polynomial produced by the Berlekamp-Massey stage.
- Evaluates sigma(x) serially at every codeword position, one position per clock.
- Emits a per-bit error flag stream, in transmission order, for the correction XOR stage.
- Reports the root count and a decoding-failure flag at end of frame.

---
 rtl/bch_chien_search.sv | 130 +++++++++++++
 1 files changed

// File: rtl/bch_chien_search.sv
// Serial Chien search over GF(2^M): evaluates sigma(x) at one codeword position per clock.
// Emits per-bit error flags in transmission order, plus root count and failure flag at end of frame.
module bch_chien_search #(
    parameter int M       = 4,
    parameter int N       = 2**M - 1,
    parameter int T       = 3,
    parameter int IRRPOLY = 'h13
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              iloc_poly_val,
    input  logic [T:0][M-1:0] iloc_poly,
    input  logic [M-1:0]      iloc_poly_deg,
    input  logic              iloc_failed,
    output logic              ordy,
    output logic              oerr_val,
    output logic              oerr_sop,
    output logic              oerr_eop,
    output logic              oerr_bit,
    output logic [M-1:0]      oerr_cnt,
    output logic              odecfail
);

    typedef logic [M-1:0] data_t;
    typedef enum logic {IDLE, SCAN} state_t;

    localparam data_t POLY_LOW = data_t'(IRRPOLY);
    localparam data_t LAST_IDX = data_t'(N - 1);
    localparam data_t CNT_MAX  = '1;

    function automatic data_t mul_alpha(input data_t x);
        data_t r;
        r = {x[M-2:0], 1'b0};
        if (x[M-1]) r = r ^ POLY_LOW;
        return r;
    endfunction

    // Constant multiply by alpha^k; k is elaboration-constant at every call site.
    function automatic data_t mul_alpha_pow(input data_t x, input int k);
        data_t r;
        r = x;
        for (int i = 0; i < k; i++) r = mul_alpha(r);
        return r;
    endfunction

    state_t state_q, state_d;
    data_t  c_q [T+1];
    data_t  deg_q;
    logic   failed_q;
    data_t  idx_q;
    data_t  cnt_q;
    data_t  syn;
    data_t  cnt_next;
    logic   is_root;
    logic   is_last;

    always_ff @(posedge iclk) begin
        if (ireset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: default assignment first so no path through the block infers a latch.
        state_d = state_q;
        case (state_q)
            IDLE: if (iloc_poly_val) state_d = SCAN;
            SCAN: if (is_last)       state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_comb ordy = (state_q == IDLE);

    // Sum of the running terms is sigma(alpha^(idx+1)).
    always_comb begin
        syn = '0;
        for (int j = 0; j <= T; j++) syn = syn ^ c_q[j];
    end

    assign is_root  = (syn == '0);
    assign is_last  = (idx_q == LAST_IDX);
    assign cnt_next = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + data_t'(is_root);

    // NOTE: c_q, deg_q and failed_q carry no reset; they are always loaded before use.
    always_ff @(posedge iclk) begin
        for (int j = 0; j <= T; j++) begin
            if (state_q == IDLE && iloc_poly_val) c_q[j] <= mul_alpha_pow(iloc_poly[j], j);
            else if (state_q == SCAN)             c_q[j] <= mul_alpha_pow(c_q[j], j);
        end
        if (state_q == IDLE && iloc_poly_val) begin
            deg_q    <= iloc_poly_deg;
            failed_q <= iloc_failed;
        end
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            idx_q    <= '0;
            cnt_q    <= '0;
            oerr_val <= 1'b0;
            oerr_sop <= 1'b0;
            oerr_eop <= 1'b0;
            oerr_bit <= 1'b0;
            oerr_cnt <= '0;
            odecfail <= 1'b0;
        end else if (state_q == SCAN) begin
            // NOTE: non-blocking so every register sees pre-edge values of the others.
            oerr_val <= 1'b1;
            oerr_bit <= is_root;
            oerr_sop <= (idx_q == '0);
            oerr_eop <= is_last;
            cnt_q    <= cnt_next;
            idx_q    <= idx_q + data_t'(1);
            if (is_last) begin
                oerr_cnt <= cnt_next;
                odecfail <= failed_q | (cnt_next != deg_q) | (deg_q > data_t'(T));
            end
        end else begin
            oerr_val <= 1'b0;
            oerr_sop <= 1'b0;
            oerr_eop <= 1'b0;
            oerr_bit <= 1'b0;
            if (iloc_poly_val) begin
                idx_q <= '0;
                cnt_q <= '0;
            end
        end
    end

endmodule
